// File: rtl/top_if.sv
// Instruction fetch stage: on-chip program memory loaded word by word, then fetched
// through a PC with branch and stall handling. Fetch stops when it reaches the halt word.
module top_if #(
  parameter int LENGTH_INSTRUCTION = 32,
  parameter int CANT_BITS_ADDR     = 11,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_OPCODE = 32'hFFFFFFFF
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_write_en,
  input  logic [CANT_BITS_ADDR-1:0]     i_write_addr,
  input  logic [LENGTH_INSTRUCTION-1:0] i_write_data,
  input  logic                          i_start,
  input  logic                          i_branch_control,
  input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
  input  logic                          i_stall,
  input  logic                          i_enable_pipeline,
  input  logic                          i_enable_etapa,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]     o_pc,
  output logic                          o_halt,
  output logic                          o_loading
);

  localparam int DEPTH = 1 << CANT_BITS_ADDR;

  typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;

  state_t                          state;
  logic [CANT_BITS_ADDR-1:0]       pc;
  logic [CANT_BITS_ADDR-1:0]       pc_inc;
  logic [LENGTH_INSTRUCTION-1:0]   fetch_word;
  logic                            adv;
  logic [LENGTH_INSTRUCTION-1:0]   mem [DEPTH];

  assign pc_inc     = pc + {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};
  assign fetch_word = mem[pc];
  assign adv        = (state == RUN) & i_enable_pipeline & i_enable_etapa & ~i_stall;

  // Memory has no reset so a soft reset keeps the loaded program
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset && state == LOAD && i_write_en)
      mem[i_write_addr] <= i_write_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state          <= LOAD;
      pc             <= '0;
      o_instruction  <= '0;
      o_out_adder_pc <= '0;
    end else begin
      case (state)
        LOAD: begin
          o_instruction <= '0;
          if (i_start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (adv) begin
            o_instruction  <= fetch_word;
            o_out_adder_pc <= pc_inc;
            // The halt word itself is issued downstream; PC freezes on it
            if (fetch_word == HALT_OPCODE)
              state <= HALTED;
            else
              pc <= i_branch_control ? i_branch_dir : pc_inc;
          end
        end
        HALTED: begin
          o_instruction <= '0;
          if (i_start) begin
            state <= LOAD;
            pc    <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign o_pc      = pc;
  assign o_halt    = (state == HALTED);
  assign o_loading = (state == LOAD);

endmodule

// File: tb/tb_top_if.sv
// Directed bench for top_if: load, run, branch, stall, PC wrap, halt, reload and reset.
module tb_top_if;

  localparam int W = 32;
  localparam int A = 11;

  logic          clk = 1'b0;
  logic          soft_reset;
  logic          write_en;
  logic [A-1:0]  write_addr;
  logic [W-1:0]  write_data;
  logic          start;
  logic          branch_control;
  logic [A-1:0]  branch_dir;
  logic          stall;
  logic          enable_pipeline;
  logic          enable_etapa;
  logic [W-1:0]  instruction;
  logic [A-1:0]  out_adder_pc;
  logic [A-1:0]  pc;
  logic          halt;
  logic          loading;

  int passed = 0;
  int total  = 0;

  top_if #(
    .LENGTH_INSTRUCTION(W),
    .CANT_BITS_ADDR(A),
    .HALT_OPCODE(32'hFFFFFFFF)
  ) dut (
    .i_clock(clk),
    .i_soft_reset(soft_reset),
    .i_write_en(write_en),
    .i_write_addr(write_addr),
    .i_write_data(write_data),
    .i_start(start),
    .i_branch_control(branch_control),
    .i_branch_dir(branch_dir),
    .i_stall(stall),
    .i_enable_pipeline(enable_pipeline),
    .i_enable_etapa(enable_etapa),
    .o_instruction(instruction),
    .o_out_adder_pc(out_adder_pc),
    .o_pc(pc),
    .o_halt(halt),
    .o_loading(loading)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic load_word(input logic [A-1:0] addr, input logic [W-1:0] data);
    write_en   = 1'b1;
    write_addr = addr;
    write_data = data;
    step();
    write_en   = 1'b0;
  endtask

  initial begin
    soft_reset = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
    start = 1'b0; branch_control = 1'b0; branch_dir = '0; stall = 1'b0;
    enable_pipeline = 1'b0; enable_etapa = 1'b0;
    step(); step();
    soft_reset = 1'b0;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_adder", 32'(out_adder_pc), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_loading", 32'(loading), 32'h1);

    // First program, ending in a halt word
    load_word(11'd0, 32'h20010005);
    load_word(11'd1, 32'h20020007);
    load_word(11'd2, 32'h00221820);
    load_word(11'd3, 32'hFFFFFFFF);
    enable_pipeline = 1'b1; enable_etapa = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("run_loading", 32'(loading), 32'h0);
    check("run_pc0", 32'(pc), 32'h0);
    check("run_instr0", instruction, 32'h0);
    step();
    check("p1_instr0", instruction, 32'h20010005);
    check("p1_adder0", 32'(out_adder_pc), 32'h1);
    check("p1_pc1", 32'(pc), 32'h1);
    step(); check("p1_instr1", instruction, 32'h20020007);
    step(); check("p1_instr2", instruction, 32'h00221820);
    step();
    check("p1_halt_word", instruction, 32'hFFFFFFFF);
    check("p1_halt_pc", 32'(pc), 32'h3);
    check("p1_halt_adder", 32'(out_adder_pc), 32'h4);
    check("p1_halt_flag", 32'(halt), 32'h1);
    step();
    check("p1_nop", instruction, 32'h0);
    check("p1_halt_hold", 32'(halt), 32'h1);
    check("p1_pc_hold", 32'(pc), 32'h3);

    // Back to LOAD, second program exercising branch, stall and wrap
    start = 1'b1; step(); start = 1'b0;
    check("reload_loading", 32'(loading), 32'h1);
    check("reload_pc", 32'(pc), 32'h0);
    check("reload_halt", 32'(halt), 32'h0);
    load_word(11'd3,     32'h33330003);
    load_word(11'd4,     32'h44440004);
    load_word(11'd5,     32'hFFFFFFFF);
    load_word(11'd7,     32'h77770007);
    load_word(11'h040,   32'h40404040);
    load_word(11'h7FF,   32'h7FF07FF0);
    start = 1'b1; step(); start = 1'b0;

    enable_pipeline = 1'b0; step();
    check("pipe_off_pc", 32'(pc), 32'h0);
    check("pipe_off_instr", instruction, 32'h0);
    enable_pipeline = 1'b1; enable_etapa = 1'b0;
    branch_control = 1'b1; branch_dir = 11'h055; step();
    check("etapa_off_pc", 32'(pc), 32'h0);
    enable_etapa = 1'b1; branch_control = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    check("start_in_run_loading", 32'(loading), 32'h0);
    check("start_in_run_pc", 32'(pc), 32'h1);
    write_en = 1'b1; write_addr = 11'd1; write_data = 32'hCAFEF00D;
    step(); write_en = 1'b0;
    step(); step();
    check("p2_instr3", instruction, 32'h33330003);
    check("p2_pc4", 32'(pc), 32'h4);

    branch_control = 1'b1; branch_dir = 11'h040; step();
    check("br_instr", instruction, 32'h44440004);
    check("br_adder", 32'(out_adder_pc), 32'h5);
    check("br_pc", 32'(pc), 32'h040);
    branch_dir = 11'd7; step();
    check("br2_instr", instruction, 32'h40404040);
    check("br2_pc", 32'(pc), 32'h7);

    stall = 1'b1; branch_dir = 11'h055;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_pc", i), 32'(pc), 32'h7);
      check($sformatf("stall%0d_instr", i), instruction, 32'h40404040);
    end
    stall = 1'b0; branch_dir = 11'h7FF; step(); branch_control = 1'b0;
    check("br3_instr", instruction, 32'h77770007);
    check("br3_adder", 32'(out_adder_pc), 32'h8);
    check("br3_pc", 32'(pc), 32'h7FF);
    step();
    check("wrap_instr", instruction, 32'h7FF07FF0);
    check("wrap_adder", 32'(out_adder_pc), 32'h0);
    check("wrap_pc", 32'(pc), 32'h0);
    step(); check("p2_instr0", instruction, 32'h20010005);
    step(); check("run_write_ignored", instruction, 32'h20020007);
    step(); step(); step(); step();
    check("p2_halt_word", instruction, 32'hFFFFFFFF);
    check("p2_halt_pc", 32'(pc), 32'h5);
    check("p2_halt_flag", 32'(halt), 32'h1);
    step();
    check("p2_nop", instruction, 32'h0);

    // HALTED -> LOAD, write and start in the same cycle
    start = 1'b1; step(); start = 1'b0;
    check("p3_loading", 32'(loading), 32'h1);
    check("p3_pc", 32'(pc), 32'h0);
    write_en = 1'b1; write_addr = 11'd0; write_data = 32'h12345678; start = 1'b1;
    step(); write_en = 1'b0; start = 1'b0;
    check("p3_run", 32'(loading), 32'h0);
    step();
    check("p3_instr", instruction, 32'h12345678);
    check("p3_pc1", 32'(pc), 32'h1);

    // Reset mid-run beats a simultaneous write and start
    soft_reset = 1'b1; start = 1'b1; write_en = 1'b1; write_addr = 11'd0; write_data = 32'hDEADBEEF;
    step();
    soft_reset = 1'b0; start = 1'b0; write_en = 1'b0;
    check("mrst_loading", 32'(loading), 32'h1);
    check("mrst_pc", 32'(pc), 32'h0);
    check("mrst_instr", instruction, 32'h0);
    check("mrst_adder", 32'(out_adder_pc), 32'h0);
    check("mrst_halt", 32'(halt), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    step(); check("mrst_mem0_kept", instruction, 32'h12345678);
    step(); check("mrst_mem1_kept", instruction, 32'h20020007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
